// File: rtl/edid_i2c_slave_ctrl.sv
// EDID slave transaction sequencer: decodes the slave address and the word offset,
// then streams EDID ROM bytes through the I2C byte transceiver.
module edid_i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ROM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_cond,
  input  logic              stop_cond,
  input  logic              byte_received,
  input  logic [7:0]        data_received,
  input  logic              operation_completed,
  input  logic              line_ack,
  output logic              start_operation,
  output logic              tx_data,
  output logic [7:0]        data_to_send,
  output logic              generate_ack,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_ADDR   = 3'd1,
    RX_OFFS   = 3'd2,
    RX_DATA   = 3'd3,
    FETCH0    = 3'd4,
    FETCH1    = 3'd5,
    TX_BYTE   = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t            state;
  logic [ROM_AW-1:0] offset;

  assign rom_addr  = offset;
  assign state_dbg = state;

  // Handshake: start_operation and generate_ack are single-cycle strobes toward the
  // transceiver; data_to_send and tx_data are held from start_operation until the
  // matching operation_completed, which the transceiver presents for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      offset          <= '0;
      start_operation <= 1'b0;
      tx_data         <= 1'b0;
      data_to_send    <= 8'h00;
      generate_ack    <= 1'b0;
      busy            <= 1'b0;
    end else begin
      start_operation <= 1'b0;
      generate_ack    <= 1'b0;
      if (start_cond) begin
        state           <= RX_ADDR;
        start_operation <= 1'b1;
        tx_data         <= 1'b0;
      end else if (stop_cond) begin
        state   <= IDLE;
        busy    <= 1'b0;
        tx_data <= 1'b0;
      end else begin
        case (state)
          RX_ADDR: begin
            if (byte_received) begin
              if (data_received[7:1] == SLAVE_ADDR) begin
                generate_ack <= 1'b1;
                busy         <= 1'b1;
                state        <= data_received[0] ? FETCH0 : RX_OFFS;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end else if (operation_completed) begin
              start_operation <= 1'b1;
              tx_data         <= 1'b0;
            end
          end
          RX_OFFS: begin
            if (byte_received) begin
              generate_ack <= 1'b1;
              offset       <= ROM_AW'(data_received);
              state        <= RX_DATA;
            end else if (operation_completed) begin
              start_operation <= 1'b1;
              tx_data         <= 1'b0;
            end
          end
          RX_DATA: begin
            // The ROM is read-only: written bytes are acknowledged and dropped.
            if (byte_received) begin
              generate_ack <= 1'b1;
            end else if (operation_completed) begin
              start_operation <= 1'b1;
              tx_data         <= 1'b0;
            end
          end
          FETCH0: state <= FETCH1;
          FETCH1: begin
            data_to_send    <= rom_data;
            start_operation <= 1'b1;
            tx_data         <= 1'b1;
            state           <= TX_BYTE;
          end
          TX_BYTE: begin
            if (operation_completed) begin
              offset <= offset + ROM_AW'(1);
              if (line_ack) begin
                state <= FETCH0;
              end else begin
                state   <= WAIT_STOP;
                tx_data <= 1'b0;
              end
            end
          end
          default: tx_data <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edid_i2c_slave_ctrl.sv
// Bench for edid_i2c_slave_ctrl: transaction-level EDID slave model with a
// cycle-stamped expected-event queue checked by a negedge monitor.
module tb_edid_i2c_slave_ctrl;

  localparam int         ROM_AW = 8;
  localparam logic [6:0] SLAVE  = 7'h50;
  localparam logic [1:0] K_ACK  = 2'd1;
  localparam logic [1:0] K_RX   = 2'd2;
  localparam logic [1:0] K_TX   = 2'd3;
  localparam int P_IDLE = 0, P_ADDR = 1, P_OFFS = 2, P_DATA = 3, P_READ = 4, P_IGN = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_cond = 1'b0;
  logic              stop_cond = 1'b0;
  logic              byte_received = 1'b0;
  logic [7:0]        data_received = 8'h00;
  logic              operation_completed = 1'b0;
  logic              line_ack = 1'b0;
  logic              start_operation;
  logic              tx_data;
  logic [7:0]        data_to_send;
  logic              generate_ack;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic              busy;
  logic [2:0]        state_dbg;

  logic [7:0]  rom_mem [256];
  logic [25:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_off = 0;
  int phase = P_IDLE;

  edid_i2c_slave_ctrl #(.SLAVE_ADDR(SLAVE), .ROM_AW(ROM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_cond(start_cond), .stop_cond(stop_cond),
    .byte_received(byte_received), .data_received(data_received),
    .operation_completed(operation_completed), .line_ack(line_ack),
    .start_operation(start_operation), .tx_data(tx_data), .data_to_send(data_to_send),
    .generate_ack(generate_ack), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset / synchronous ROM
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d, input int lat);
    exp_q.push_back({16'(cyc + lat), k, d});
  endtask

  // scoreboard monitor
  task automatic check_evt(input logic [1:0] k, input logic [7:0] d);
    logic [25:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got kind=%0d data=%0h at cyc %0d", k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e[9:0] !== {k, d} || e[25:10] !== 16'(cyc)) begin
        bad++;
        $display("FAIL event got kind=%0d data=%0h cyc=%0d want kind=%0d data=%0h cyc=%0d",
                 k, d, cyc, e[9:8], e[7:0], e[25:10]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (generate_ack) check_evt(K_ACK, 8'h00);
      if (start_operation) check_evt(tx_data ? K_TX : K_RX, tx_data ? data_to_send : 8'h00);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start_cond = 1'b1;
    push(K_RX, 8'h00, 1);
    phase = P_ADDR;
    tick(1);
    start_cond = 1'b0;
    tick(2);
  endtask

  task automatic do_stop();
    stop_cond = 1'b1;
    phase = P_IDLE;
    tick(1);
    stop_cond = 1'b0;
    tick(2);
  endtask

  task automatic do_start_stop();
    start_cond = 1'b1;
    stop_cond = 1'b1;
    push(K_RX, 8'h00, 1);
    phase = P_ADDR;
    tick(1);
    start_cond = 1'b0;
    stop_cond = 1'b0;
    tick(2);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    logic rearm;
    logic skip_oc;
    rearm = 1'b0;
    skip_oc = 1'b0;
    byte_received = 1'b1;
    data_received = b;
    if (phase == P_ADDR) begin
      if (b[7:1] == SLAVE) begin
        push(K_ACK, 8'h00, 1);
        if (b[0]) begin
          push(K_TX, rom_mem[model_off], 3);
          phase = P_READ;
          skip_oc = 1'b1;
        end else begin
          phase = P_OFFS;
          rearm = 1'b1;
        end
      end else begin
        phase = P_IGN;
      end
    end else if (phase == P_OFFS) begin
      push(K_ACK, 8'h00, 1);
      model_off = int'(b);
      phase = P_DATA;
      rearm = 1'b1;
    end else if (phase == P_DATA) begin
      push(K_ACK, 8'h00, 1);
      rearm = 1'b1;
    end
    tick(1);
    byte_received = 1'b0;
    data_received = 8'h00;
    tick(3);
    if (!skip_oc) begin
      operation_completed = 1'b1;
      if (rearm) push(K_RX, 8'h00, 1);
      tick(1);
      operation_completed = 1'b0;
      tick(2);
    end
  endtask

  task automatic tx_byte(input logic ack);
    operation_completed = 1'b1;
    line_ack = ack;
    model_off = (model_off + 1) % 256;
    if (ack) push(K_TX, rom_mem[model_off], 3);
    else phase = P_IGN;
    tick(1);
    operation_completed = 1'b0;
    line_ack = 1'b0;
    tick(4);
  endtask

  task automatic read_n(input int n);
    rx_byte({SLAVE, 1'b1});
    for (int i = 0; i < n - 1; i++) tx_byte(1'b1);
    tx_byte(1'b0);
    check("rom_addr_after_read", 32'(rom_addr), 32'(model_off));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_start_op"}, 32'(start_operation), 0);
    check({name, "_tx_data"}, 32'(tx_data), 0);
    check({name, "_data_to_send"}, 32'(data_to_send), 0);
    check({name, "_gen_ack"}, 32'(generate_ack), 0);
    check({name, "_rom_addr"}, 32'(rom_addr), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_state"}, 32'(state_dbg), 0);
  endtask

  initial begin
    int r;
    logic [6:0] bad_addr;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom_range(0, 255));
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);
    check_all_zero("post_reset");

    // write offset 0x10, repeated START, read 3 bytes
    do_start();
    rx_byte(8'hA0);
    check("busy_after_match", 32'(busy), 1);
    rx_byte(8'h10);
    check("rom_addr_offset", 32'(rom_addr), 32'h10);
    do_start();
    read_n(3);
    check("t1_rom_addr", 32'(rom_addr), 32'h13);
    check("t1_wait_stop", 32'(state_dbg), 7);
    check("t1_tx_data_low", 32'(tx_data), 0);
    do_stop();
    check("t1_busy_after_stop", 32'(busy), 0);
    check("t1_idle", 32'(state_dbg), 0);

    // foreign address is ignored
    do_start();
    rx_byte(8'hA4);
    check("t2_busy", 32'(busy), 0);
    check("t2_wait_stop", 32'(state_dbg), 7);
    rx_byte(8'h33);
    do_stop();

    // offset wrap
    do_start();
    rx_byte(8'hA0);
    rx_byte(8'hFF);
    do_start();
    read_n(2);
    check("t3_wrap_addr", 32'(rom_addr), 32'h01);
    do_stop();

    // STOP in the middle of a TX byte
    do_start();
    rx_byte(8'hA1);
    tx_byte(1'b1);
    check("t4_in_tx_byte", 32'(state_dbg), 6);
    do_stop();
    check("t4_busy", 32'(busy), 0);
    check("t4_idle", 32'(state_dbg), 0);
    check("t4_kept_offset", 32'(rom_addr), 32'(model_off));
    do_start();
    read_n(1);
    do_stop();

    // asynchronous reset mid-read
    do_start();
    rx_byte(8'hA1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_off = 0;
    phase = P_IDLE;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    do_start();
    read_n(1);
    do_stop();

    // START and STOP in the same cycle
    do_start_stop();
    check("t6_rx_addr", 32'(state_dbg), 1);
    read_n(2);
    do_stop();

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 3);
      do_start();
      if (r == 0) begin
        bad_addr = SLAVE ^ 7'($urandom_range(1, 127));
        rx_byte({bad_addr, 1'($urandom_range(0, 1))});
        check("rnd_ignored_busy", 32'(busy), 0);
      end else if (r == 1 || r == 3) begin
        rx_byte(8'hA0);
        rx_byte(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) rx_byte(8'($urandom_range(0, 255)));
        check("rnd_offset", 32'(rom_addr), 32'(model_off));
        if (r == 3) begin
          do_start();
          read_n($urandom_range(1, 4));
        end
      end else begin
        read_n($urandom_range(1, 4));
      end
      do_stop();
    end

    tick(10);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
